// File: rtl/sweep_burst_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweep_burst_scheduler_pkg
// Description : Shared definitions for the sweep burst scheduler, the
//               square-wave/DA sweep generator and the control front end.
//               - sbs_state_t : scheduler state encoding (IDLE/BURST/GAP/DONE)
//               - c_DEF_*     : default sweep and timing constants
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_burst_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } sbs_state_t;

    localparam int unsigned c_DEF_DIV_MIN       = 54;
    localparam int unsigned c_DEF_DIV_STEP      = 54;
    localparam int unsigned c_DEF_DIV_MAX       = 5400;
    localparam int unsigned c_DEF_BURST_PERIODS = 10000;
    localparam int unsigned c_DEF_GAP_CYCLES    = 65535;
    localparam int          c_DEF_CNT_W         = 32;

endpackage : sweep_burst_scheduler_pkg
`default_nettype wire

// File: rtl/sweep_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sweep_burst_scheduler
// Description : Runs the sweep generator through repeated frequency-sweep
//               bursts separated by silent gaps, and counts bursts.
// Ports       :
//   Sys_Clock       in   system clock, rising edge
//   nReset          in   asynchronous active-low reset
//   Start           in   begin a run (accepted only in IDLE)
//   Stop            in   abort a run (any non-IDLE state)
//   Num_Bursts      in   bursts per run, 0 = continuous (latched on Start)
//   Gen_Period_Done in   one pulse per completed generator output period
//   Gen_Enable      out  generator enable, high only in BURST
//   Gen_Half_Div    out  current half-period divider
//   Busy            out  high in BURST, GAP and DONE
//   Burst_Index     out  completed bursts in the current run
//   Done            out  one-cycle pulse when a finite run completes
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_burst_scheduler
    import sweep_burst_scheduler_pkg::*;
#(
    parameter int unsigned DIV_MIN       = c_DEF_DIV_MIN,
    parameter int unsigned DIV_STEP      = c_DEF_DIV_STEP,
    parameter int unsigned DIV_MAX       = c_DEF_DIV_MAX,
    parameter int unsigned BURST_PERIODS = c_DEF_BURST_PERIODS,
    parameter int unsigned GAP_CYCLES    = c_DEF_GAP_CYCLES,
    parameter int          CNT_W         = c_DEF_CNT_W
) (
    input  logic             Sys_Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic             Stop,
    input  logic [15:0]      Num_Bursts,
    input  logic             Gen_Period_Done,
    output logic             Gen_Enable,
    output logic [CNT_W-1:0] Gen_Half_Div,
    output logic             Busy,
    output logic [15:0]      Burst_Index,
    output logic             Done
);

    localparam logic [CNT_W-1:0] c_DIV_MIN    = CNT_W'(DIV_MIN);
    // Divider arithmetic is one bit wider so a wrapping step still reads as
    // exceeding the limit.
    localparam logic [CNT_W:0]   c_DIV_STEP_X = (CNT_W+1)'(DIV_STEP);
    localparam logic [CNT_W:0]   c_DIV_MAX_X  = (CNT_W+1)'(DIV_MAX);
    localparam logic [CNT_W-1:0] c_PERIODS    = CNT_W'(BURST_PERIODS);
    localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    sbs_state_t       r_state;
    logic [15:0]      r_num_bursts;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_gap_cnt;

    logic [CNT_W:0]   w_next_div;
    logic [CNT_W-1:0] w_period_nxt;
    logic [15:0]      w_idx_nxt;
    logic             w_burst_end;
    logic             w_run_done;

    always_comb begin
        w_next_div   = {1'b0, Gen_Half_Div} + c_DIV_STEP_X;
        w_period_nxt = r_period_cnt + 1'b1;
        w_idx_nxt    = Burst_Index + 16'd1;
        w_burst_end  = (w_period_nxt == c_PERIODS) || (w_next_div > c_DIV_MAX_X);
        w_run_done   = (r_num_bursts != 16'd0) && (w_idx_nxt == r_num_bursts);
    end

    always_ff @(posedge Sys_Clock or negedge nReset) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_num_bursts <= '0;
            r_period_cnt <= '0;
            r_gap_cnt    <= '0;
            Gen_Enable   <= 1'b0;
            Gen_Half_Div <= c_DIV_MIN;
            Busy         <= 1'b0;
            Burst_Index  <= '0;
            Done         <= 1'b0;
        end else begin
            Done <= 1'b0;
            // Stop outranks everything once a run is active; the common abort
            // path leaves Burst_Index untouched and never pulses Done.
            if (r_state != IDLE && Stop) begin
                r_state      <= IDLE;
                Gen_Enable   <= 1'b0;
                Busy         <= 1'b0;
                Gen_Half_Div <= c_DIV_MIN;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (Start) begin
                            r_num_bursts <= Num_Bursts;
                            Burst_Index  <= '0;
                            r_period_cnt <= '0;
                            Gen_Half_Div <= c_DIV_MIN;
                            Gen_Enable   <= 1'b1;
                            Busy         <= 1'b1;
                            r_state      <= BURST;
                        end
                    end
                    BURST: begin
                        if (Gen_Period_Done) begin
                            if (w_burst_end) begin
                                // Divider is left at the last swept value.
                                Burst_Index <= w_idx_nxt;
                                Gen_Enable  <= 1'b0;
                                if (w_run_done) begin
                                    Done    <= 1'b1;
                                    r_state <= DONE;
                                end else begin
                                    r_gap_cnt <= '0;
                                    r_state   <= GAP;
                                end
                            end else begin
                                r_period_cnt <= w_period_nxt;
                                Gen_Half_Div <= w_next_div[CNT_W-1:0];
                            end
                        end
                    end
                    GAP: begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                        if (r_gap_cnt == c_GAP_LAST) begin
                            Gen_Half_Div <= c_DIV_MIN;
                            r_period_cnt <= '0;
                            Gen_Enable   <= 1'b1;
                            r_state      <= BURST;
                        end
                    end
                    DONE: begin
                        Busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        Gen_Enable <= 1'b0;
                        Busy       <= 1'b0;
                        r_state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : sweep_burst_scheduler
`default_nettype wire

// File: doc/sweep_burst_scheduler.md
Name: sweep_burst_scheduler

Overview:
Sequences the square-wave/DA sweep generator through repeated frequency-sweep bursts separated by silent gaps. The generator receives an enable and a half-period divider value, and returns a one-cycle pulse per completed output period. The scheduler steps the divider after each period, ends a burst on a period-count or divider limit, times the gap, and counts bursts. It sits between the control/SPI front end (Start/Stop/Num_Bursts) and the generator.

Parameters:
DIV_MIN, 54, first half-period divider of each burst (Sys_Clock cycles)
DIV_STEP, 54, divider increment applied after each completed output period
DIV_MAX, 5400, largest legal divider; a step that would exceed it ends the burst
BURST_PERIODS, 10000, maximum output periods per burst (>=1)
GAP_CYCLES, 65535, Sys_Clock cycles of disabled output between bursts (>=1)
CNT_W, 32, width of divider, period and gap counters

Ports:
Sys_Clock  in  1  system clock; all logic on rising edge
nReset  in  1  asynchronous active-low reset
Start  in  1  one-cycle request to begin a run; honoured only in IDLE
Stop  in  1  one-cycle abort; honoured in any non-IDLE state
Num_Bursts  in  16  bursts per run, latched on accepted Start; 0 = continuous
Gen_Period_Done  in  1  pulse from generator per completed output period
Gen_Enable  out  1  generator enable; high only in BURST
Gen_Half_Div  out  CNT_W  current half-period divider to generator
Busy  out  1  high in BURST, GAP and DONE
Burst_Index  out  16  completed bursts in current run
Done  out  1  one-cycle pulse when a finite run completes

Behaviour:
- Reset, asynchronous: state=IDLE, Gen_Enable=0, Gen_Half_Div=DIV_MIN, Busy=0, Burst_Index=0, Done=0, all internal counters 0.
- All outputs are registered. Decisions made in cycle N are visible in cycle N+1.
- IDLE, Start=1, Stop=0: latch Num_Bursts. Set Burst_Index=0, period_cnt=0, Gen_Half_Div=DIV_MIN. Go to BURST. Gen_Enable and Busy rise the next cycle.
- BURST, Gen_Period_Done=1:
  - next_div = Gen_Half_Div + DIV_STEP, computed at CNT_W+1 bits so overflow counts as > DIV_MAX.
  - The burst ends if period_cnt+1 == BURST_PERIODS or next_div > DIV_MAX. Otherwise period_cnt+1 is stored and Gen_Half_Div = next_div.
- Burst end:
  - Burst_Index+1, wrapping 0xFFFF->0 in continuous mode.
  - If latched Num_Bursts != 0 and Burst_Index+1 == Num_Bursts, go to DONE. Otherwise go to GAP with gap_cnt=0.
  - Gen_Enable drops the next cycle in either case.
- GAP:
  - gap_cnt increments every cycle. When gap_cnt == GAP_CYCLES-1, go to BURST with Gen_Half_Div=DIV_MIN and period_cnt=0.
  - Gen_Enable is therefore low for exactly GAP_CYCLES cycles.
- DONE: Done=1 for exactly one cycle, Busy=1. Then IDLE. Burst_Index holds its final value until the next Start.
- Stop in BURST, GAP or DONE: go to IDLE next cycle with Gen_Enable=0 and Busy=0. No Done pulse. Burst_Index holds. Gen_Half_Div returns to DIV_MIN.
- Priority, highest first: nReset, Stop, Gen_Period_Done/gap terminal, Start.
  - Stop coincident with Gen_Period_Done: abort; the period is not counted and the divider is not stepped.
- Ignored inputs:
  - Start outside IDLE.
  - Stop in IDLE.
  - Gen_Period_Done outside BURST.
  - Num_Bursts changes after latching.
- If DIV_MIN > DIV_MAX, each burst ends on its first period. This is legal and not flagged.
- State encoding: IDLE=0, BURST=1, GAP=2, DONE=3. Unreachable codes return to IDLE.

Decomposition:
- Shared package: state enum (IDLE/BURST/GAP/DONE) and default constants DIV_MIN/DIV_STEP/DIV_MAX/BURST_PERIODS/GAP_CYCLES, reused by the generator and the front end.
- No sub-module required. Single FSM plus counters, roughly 150-250 lines.

Test Plan:
1. DIV_MIN=2, DIV_STEP=2, DIV_MAX=8, BURST_PERIODS=10, Num_Bursts=1, Start, then 4 Gen_Period_Done pulses -> Gen_Half_Div 2,4,6,8, burst ends on 4th pulse (10>8), Done pulse one cycle later, Burst_Index=1, Busy falls after Done.
2. DIV_MAX=1000, BURST_PERIODS=3, Num_Bursts=1 -> burst ends on 3rd pulse with Gen_Half_Div=6, Done asserted.
3. Num_Bursts=2, GAP_CYCLES=5 -> Gen_Enable low exactly 5 cycles between bursts, Gen_Half_Div=2 at second burst start, Done after second burst, Burst_Index=2.
4. Stop asserted in the same cycle as Gen_Period_Done mid-burst -> IDLE next cycle, Gen_Enable=0, Busy=0, no Done, Gen_Half_Div=2, Burst_Index unchanged.
5. nReset pulsed low mid-GAP -> all outputs at reset values immediately, without waiting for a clock edge. Start after release -> normal run.
6. Num_Bursts=0, Start pulsed again during BURST -> second Start ignored, run continues through 3+ bursts with no Done, Burst_Index increments 1,2,3.
